mem_sp_param: RTL and testbench

- Parametrised single-port synchronous SRAM model. Generalises the fixed 16384x64 testbench memory.
- Adds configurable width, depth and read latency, per-byte write enables, and a read-valid strobe.
- Adds a hardware zero-fill sweep after reset or on request.
- Used as the packet/bit-buffer backing store in the decoder testbench and FPGA top, with behaviour identical in simulation and synthesis.

---
 rtl/mem_sp_param.sv | 139 +++++++++++++
 tb/tb_mem_sp_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_sp_param.sv
// ============================================================================
// mem_sp_param : parametrised single-port synchronous SRAM with byte enables,
//                pipelined read-valid strobe and hardware zero-fill sweep.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mem_sp_param #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 14,
  parameter int BYTE_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ceb,
  input  logic                       web,
  input  logic [DATA_W/BYTE_W-1:0]   bweb,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       clr_req,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rvalid,
  output logic                       busy
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  if (((DATA_W % BYTE_W) != 0) || (RD_LAT < 1) || (RD_LAT > 3)) begin : g_param_check
    $error("mem_sp_param: DATA_W must be a multiple of BYTE_W and RD_LAT must be 1..3");
  end

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              sweep_addr_q, sweep_addr_d;
  logic [RD_LAT-1:0]              rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0][DATA_W-1:0]  rd_data_q, rd_data_d;

  logic                           mem_we;
  logic [ADDR_W-1:0]              mem_waddr;
  logic [DATA_W-1:0]              mem_wdata;
  logic [NB-1:0]                  mem_lane_en;
  logic                           rd_req;

  logic [DATA_W-1:0]              mem_array [DEPTH];

  // Sweep and user accesses share the single write port; clr_req overrides both.
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    mem_we       = 1'b0;
    mem_waddr    = addr;
    mem_wdata    = wdata;
    mem_lane_en  = ~bweb;
    rd_req       = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = sweep_addr_q;
        mem_wdata    = '0;
        mem_lane_en  = '1;
        sweep_addr_d = sweep_addr_q + ADDR_W'(1);
        if (&sweep_addr_q) begin
          state_d = ST_READY;
        end
      end
      default: begin
        if (!ceb && !clr_req) begin
          if (!web) begin
            mem_we = 1'b1;
          end else begin
            rd_req = 1'b1;
          end
        end
      end
    endcase

    if (clr_req) begin
      state_d      = ST_CLEAR;
      sweep_addr_d = '0;
    end
  end

  // Each stage only loads when a result arrives, so the output stage holds
  // the last read value while rvalid is low.
  always_comb begin
    rd_vld_d     = rd_vld_q;
    rd_data_d    = rd_data_q;
    rd_vld_d[0]  = rd_req;
    if (rd_req) begin
      rd_data_d[0] = mem_array[addr];
    end
    for (int k = 1; k < RD_LAT; k++) begin
      rd_vld_d[k] = rd_vld_q[k-1];
      if (rd_vld_q[k-1]) begin
        rd_data_d[k] = rd_data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      sweep_addr_q <= '0;
      rd_vld_q     <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      rd_vld_q     <= rd_vld_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_lane_en[i]) begin
          mem_array[mem_waddr][i*BYTE_W +: BYTE_W] <= mem_wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rdata  = rd_data_q[RD_LAT-1];
  assign rvalid = rd_vld_q[RD_LAT-1];
  assign busy   = (state_q == ST_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_mem_sp_param.sv
// ============================================================================
// tb_mem_sp_param : directed self-checking bench for mem_sp_param across
//                   RD_LAT / INIT_CLEAR configurations sharing one stimulus bus.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_mem_sp_param;

  logic        clk;
  logic        rst_n;
  logic        ceb;
  logic        web;
  logic [7:0]  bweb;
  logic [3:0]  addr;
  logic [63:0] wdata;
  logic        clr_req;

  logic [63:0] rdata1, rdata2, rdata3, rdata4;
  logic        rvalid1, rvalid2, rvalid3, rvalid4;
  logic        busy1, busy2, busy3, busy4;

  int n_cmp;
  int n_fail;
  int cnt;

  mem_sp_param #(.DATA_W(64), .ADDR_W(4), .BYTE_W(8), .RD_LAT(1), .INIT_CLEAR(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .ceb(ceb), .web(web), .bweb(bweb), .addr(addr),
    .wdata(wdata), .clr_req(clr_req), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1));

  mem_sp_param #(.DATA_W(64), .ADDR_W(4), .BYTE_W(8), .RD_LAT(2), .INIT_CLEAR(1)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .ceb(ceb), .web(web), .bweb(bweb), .addr(addr),
    .wdata(wdata), .clr_req(clr_req), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2));

  mem_sp_param #(.DATA_W(64), .ADDR_W(4), .BYTE_W(8), .RD_LAT(3), .INIT_CLEAR(1)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .ceb(ceb), .web(web), .bweb(bweb), .addr(addr),
    .wdata(wdata), .clr_req(clr_req), .rdata(rdata3), .rvalid(rvalid3), .busy(busy3));

  mem_sp_param #(.DATA_W(64), .ADDR_W(4), .BYTE_W(8), .RD_LAT(2), .INIT_CLEAR(0)) u_noclr (
    .clk(clk), .rst_n(rst_n), .ceb(ceb), .web(web), .bweb(bweb), .addr(addr),
    .wdata(wdata), .clr_req(clr_req), .rdata(rdata4), .rvalid(rvalid4), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    ceb = 1'b1; web = 1'b1; bweb = 8'hFF; clr_req = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
    ceb = 1'b0; web = 1'b0; addr = a; wdata = d; bweb = be;
    @(negedge clk);
    idle();
  endtask

  task automatic rd_drive(input logic [3:0] a);
    ceb = 1'b0; web = 1'b1; addr = a; bweb = 8'hFF;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (busy1 !== 1'b1) begin $display("FAIL reset_busy_clr: got %b exp 1", busy1); n_fail++; end
    n_cmp++; if (busy4 !== 1'b0) begin $display("FAIL reset_busy_noclr: got %b exp 0", busy4); n_fail++; end
    n_cmp++; if (rvalid1 !== 1'b0 || rvalid3 !== 1'b0) begin $display("FAIL reset_rvalid: got %b/%b exp 0/0", rvalid1, rvalid3); n_fail++; end
    n_cmp++; if (rdata1 !== 64'd0 || rdata3 !== 64'd0) begin $display("FAIL reset_rdata: got %h/%h exp 0", rdata1, rdata3); n_fail++; end
  endtask

  task automatic test_init_sweep();
    rst_n = 1'b1;
    cnt = 0;
    while (busy1 === 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
    n_cmp++; if (cnt !== 16) begin $display("FAIL init_sweep_len: got %0d cycles exp 16", cnt); n_fail++; end
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        n_cmp++;
        if (rvalid1 !== 1'b1 || rdata1 !== 64'd0) begin
          $display("FAIL init_read_zero[%0d]: got rvalid=%b rdata=%h exp 1/0", i-1, rvalid1, rdata1); n_fail++;
        end
      end
      if (i < 16) rd_drive(4'(i)); else idle();
      @(negedge clk);
    end
  endtask

  task automatic test_byte_write();
    wr(4'd5, 64'h0123456789ABCDEF, 8'h00);
    wr(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
    rd_drive(4'd5); @(negedge clk); idle();
    n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== 64'h01234567FFFFFFFF) begin
      $display("FAIL byte_lane_read: got rvalid=%b rdata=%h exp 1/01234567ffffffff", rvalid1, rdata1); n_fail++; end
    @(negedge clk);
    n_cmp++; if (rvalid1 !== 1'b0 || rdata1 !== 64'h01234567FFFFFFFF) begin
      $display("FAIL rdata_hold: got rvalid=%b rdata=%h exp 0/01234567ffffffff", rvalid1, rdata1); n_fail++; end
    wr(4'd5, 64'd0, 8'hFF);
    rd_drive(4'd5); @(negedge clk); idle();
    n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== 64'h01234567FFFFFFFF) begin
      $display("FAIL bweb_all_ones_noop: got rvalid=%b rdata=%h exp 1/01234567ffffffff", rvalid1, rdata1); n_fail++; end
  endtask

  task automatic test_back_to_back();
    wr(4'd1, 64'h11, 8'h00);
    wr(4'd2, 64'h22, 8'h00);
    wr(4'd3, 64'h33, 8'h00);
    rd_drive(4'd1); @(negedge clk);
    n_cmp++; if (rvalid3 !== 1'b0) begin $display("FAIL lat3_early1: got rvalid=%b exp 0", rvalid3); n_fail++; end
    rd_drive(4'd2); @(negedge clk);
    n_cmp++; if (rvalid3 !== 1'b0) begin $display("FAIL lat3_early2: got rvalid=%b exp 0", rvalid3); n_fail++; end
    rd_drive(4'd3); @(negedge clk); idle();
    n_cmp++; if (rvalid3 !== 1'b1 || rdata3 !== 64'h11) begin $display("FAIL lat3_beat0: got %b/%h exp 1/11", rvalid3, rdata3); n_fail++; end
    @(negedge clk);
    n_cmp++; if (rvalid3 !== 1'b1 || rdata3 !== 64'h22) begin $display("FAIL lat3_beat1: got %b/%h exp 1/22", rvalid3, rdata3); n_fail++; end
    @(negedge clk);
    n_cmp++; if (rvalid3 !== 1'b1 || rdata3 !== 64'h33) begin $display("FAIL lat3_beat2: got %b/%h exp 1/33", rvalid3, rdata3); n_fail++; end
    @(negedge clk);
    n_cmp++; if (rvalid3 !== 1'b0 || rdata3 !== 64'h33) begin $display("FAIL lat3_hold: got %b/%h exp 0/33", rvalid3, rdata3); n_fail++; end
  endtask

  task automatic test_clr_req();
    rd_drive(4'd2); @(negedge clk);
    n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== 64'h22) begin $display("FAIL pre_clr_read: got %b/%h exp 1/22", rvalid1, rdata1); n_fail++; end
    ceb = 1'b0; web = 1'b0; addr = 4'd7; wdata = 64'hDEAD_BEEF_0000_0007; bweb = 8'h00; clr_req = 1'b1;
    @(negedge clk); idle();
    n_cmp++; if (busy1 !== 1'b1) begin $display("FAIL clr_busy_rise: got %b exp 1", busy1); n_fail++; end
    rd_drive(4'd1); @(negedge clk); idle();
    n_cmp++; if (rvalid1 !== 1'b0) begin $display("FAIL read_while_busy: got rvalid=%b exp 0", rvalid1); n_fail++; end
    n_cmp++; if (rvalid3 !== 1'b1 || rdata3 !== 64'h22) begin $display("FAIL inflight_across_clr: got %b/%h exp 1/22", rvalid3, rdata3); n_fail++; end
    cnt = 1;
    while (busy1 === 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
    n_cmp++; if (cnt !== 16) begin $display("FAIL clr_sweep_len: got %0d cycles exp 16", cnt); n_fail++; end
    rd_drive(4'd7); @(negedge clk); idle();
    n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== 64'd0) begin $display("FAIL clr_addr7_zero: got %b/%h exp 1/0", rvalid1, rdata1); n_fail++; end
    rd_drive(4'd1); @(negedge clk); idle();
    n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== 64'd0) begin $display("FAIL clr_addr1_zero: got %b/%h exp 1/0", rvalid1, rdata1); n_fail++; end
  endtask

  task automatic test_reset_midway();
    wr(4'd3, 64'h33, 8'h00);
    rd_drive(4'd3); @(negedge clk); idle();
    n_cmp++; if (rvalid2 !== 1'b0) begin $display("FAIL lat2_early: got rvalid=%b exp 0", rvalid2); n_fail++; end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (rvalid2 !== 1'b0 || rdata2 !== 64'd0) begin $display("FAIL rst_flush_lat2: got %b/%h exp 0/0", rvalid2, rdata2); n_fail++; end
    @(negedge clk);
    n_cmp++; if (rvalid3 !== 1'b0 || rvalid2 !== 1'b0) begin $display("FAIL rst_flush_lat3: got %b/%b exp 0/0", rvalid3, rvalid2); n_fail++; end
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    n_cmp++; if (busy2 !== 1'b1) begin $display("FAIL mid_sweep_busy: got %b exp 1", busy2); n_fail++; end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy2 !== 1'b1 || rvalid2 !== 1'b0) begin $display("FAIL mid_sweep_reset: got busy=%b rvalid=%b exp 1/0", busy2, rvalid2); n_fail++; end
    rst_n = 1'b1;
    cnt = 0;
    while (busy2 === 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
    n_cmp++; if (cnt !== 16) begin $display("FAIL restart_sweep_len: got %0d cycles exp 16", cnt); n_fail++; end
  endtask

  task automatic test_no_init_clear();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy4 !== 1'b0 || busy1 !== 1'b1) begin $display("FAIL noclr_reset_busy: got %b/%b exp 0/1", busy4, busy1); n_fail++; end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy4 !== 1'b0) begin $display("FAIL noclr_ready: got busy=%b exp 0", busy4); n_fail++; end
    wr(4'd15, 64'hCAFEF00D_12345678, 8'h00);
    rd_drive(4'd15); @(negedge clk); idle();
    n_cmp++; if (rvalid4 !== 1'b0) begin $display("FAIL noclr_lat2_early: got rvalid=%b exp 0", rvalid4); n_fail++; end
    @(negedge clk);
    n_cmp++; if (rvalid4 !== 1'b1 || rdata4 !== 64'hCAFEF00D_12345678) begin
      $display("FAIL noclr_read15: got %b/%h exp 1/cafef00d12345678", rvalid4, rdata4); n_fail++; end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    addr   = 4'd0;
    wdata  = 64'd0;
    idle();
    test_reset();
    test_init_sweep();
    test_byte_write();
    test_back_to_back();
    test_clr_req();
    test_reset_midway();
    test_no_init_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
